// File: rtl/add_jump_unit_core_pkg.sv
// Shared CPU definitions for the fetch-path address units.
package cpu_pkg;

    localparam int ADDR_W       = 32;
    localparam int OFFSET_SHIFT = 2;

    typedef logic [ADDR_W-1:0] addr_t;

    // Word offset to byte offset; bits shifted past the MSB are dropped.
    function automatic addr_t scale_offset(input addr_t offset);
        return addr_t'(offset << OFFSET_SHIFT);
    endfunction

endpackage

// File: rtl/add_jump_unit_core_if.sv
// Request/result bundle between the fetch stage and the branch-target unit.
interface add_jump_unit_core_if;
    import cpu_pkg::*;

    logic  branch_command;
    addr_t sign_extand;
    addr_t pc_addr;
    addr_t jump_addr;
    logic  jump_taken;

    modport master (
        output branch_command,
        output sign_extand,
        output pc_addr,
        input  jump_addr,
        input  jump_taken
    );

    modport slave (
        input  branch_command,
        input  sign_extand,
        input  pc_addr,
        output jump_addr,
        output jump_taken
    );

endinterface

// File: rtl/add_jump_unit_core_branch_target_calc.sv
// Combinational branch target: PC plus the word-scaled signed offset.
module branch_target_calc
    import cpu_pkg::*;
(
    input  addr_t pc,
    input  addr_t offset,
    output addr_t target
);

    // Carry-out is discarded, so targets wrap modulo 2^ADDR_W.
    assign target = pc + scale_offset(offset);

endmodule

// File: rtl/add_jump_unit_core.sv
// Registered next-address unit: branch target when branching, PC otherwise.
module add_jump_unit_core
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    add_jump_unit_core_if.slave  bus
);

    addr_t target;
    addr_t next_addr;

    branch_target_calc u_target (
        .pc     (bus.pc_addr),
        .offset (bus.sign_extand),
        .target (target)
    );

    assign next_addr = bus.branch_command ? target : bus.pc_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.jump_addr  <= '0;
            bus.jump_taken <= 1'b0;
        end else begin
            bus.jump_addr  <= next_addr;
            bus.jump_taken <= bus.branch_command;
        end
    end

endmodule

// File: tb/tb_add_jump_unit_core.sv
// Directed self-checking bench for add_jump_unit_core.
module tb_add_jump_unit_core;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    addr_t prev_addr;
    logic  prev_taken;
    logic  prev_valid;

    add_jump_unit_core_if bus ();

    add_jump_unit_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one input vector, confirm the outputs hold until the edge, then
    // confirm the registered result one edge later.
    task automatic apply_stimulus(input string tag, input logic r, input logic b,
                                  input addr_t pc, input addr_t off,
                                  input addr_t exp_addr, input logic exp_taken);
        @(negedge clk);
        rst                = r;
        bus.branch_command = b;
        bus.pc_addr        = pc;
        bus.sign_extand    = off;
        #1;
        if (prev_valid) begin
            check_output({tag, "_hold_addr"}, bus.jump_addr, prev_addr);
            check_output({tag, "_hold_taken"}, {31'b0, bus.jump_taken}, {31'b0, prev_taken});
        end
        @(posedge clk);
        #1;
        check_output({tag, "_addr"}, bus.jump_addr, exp_addr);
        check_output({tag, "_taken"}, {31'b0, bus.jump_taken}, {31'b0, exp_taken});
        prev_addr  = exp_addr;
        prev_taken = exp_taken;
        prev_valid = 1'b1;
    endtask

    initial begin
        compared           = 0;
        mismatched         = 0;
        prev_valid         = 1'b0;
        prev_addr          = '0;
        prev_taken         = 1'b0;
        rst                = 1'b1;
        bus.branch_command = 1'b0;
        bus.pc_addr        = '0;
        bus.sign_extand    = '0;

        // Reset held for two cycles with non-zero inputs present
        apply_stimulus("reset0", 1'b1, 1'b1, 32'h0000_1234, 32'h0000_0005, 32'h0, 1'b0);
        apply_stimulus("reset1", 1'b1, 1'b1, 32'h0000_5678, 32'h0000_0007, 32'h0, 1'b0);

        apply_stimulus("fwd",      1'b0, 1'b1, 32'd10,        32'd20,        32'd90,        1'b1);
        apply_stimulus("nobranch", 1'b0, 1'b0, 32'h0040_0010, 32'h0000_0005, 32'h0040_0010, 1'b0);
        apply_stimulus("backward", 1'b0, 1'b1, 32'h0040_0020, 32'hFFFF_FFFC, 32'h0040_0010, 1'b1);
        apply_stimulus("wrap",     1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0002, 32'h0000_0004, 1'b1);
        apply_stimulus("msbdrop",  1'b0, 1'b1, 32'h0000_0100, 32'h8000_0001, 32'h0000_0104, 1'b1);
        apply_stimulus("zerooff",  1'b0, 1'b1, 32'h0000_0200, 32'h0000_0000, 32'h0000_0200, 1'b1);

        // Alternating branch/no-branch with a fresh PC every cycle
        apply_stimulus("alt0", 1'b0, 1'b1, 32'h0000_1000, 32'h0000_0010, 32'h0000_1040, 1'b1);
        apply_stimulus("alt1", 1'b0, 1'b0, 32'h0000_2000, 32'h0000_0010, 32'h0000_2000, 1'b0);
        apply_stimulus("alt2", 1'b0, 1'b1, 32'h0000_3000, 32'hFFFF_FF00, 32'h0000_2C00, 1'b1);
        apply_stimulus("alt3", 1'b0, 1'b0, 32'h0000_4004, 32'hFFFF_FF00, 32'h0000_4004, 1'b0);
        apply_stimulus("alt4", 1'b0, 1'b1, 32'h7FFF_FFF0, 32'h0000_0004, 32'h8000_0000, 1'b1);

        // Reset wins over an active branch
        apply_stimulus("rstprio", 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0001, 32'h0, 1'b0);
        apply_stimulus("recover", 1'b0, 1'b1, 32'h0000_1000, 32'h0000_0001, 32'h0000_1004, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/add_jump_unit_core.md
Name: add_jump_unit_core

Overview:
- Branch-target address unit for the MIPS CPU fetch path.
- When a branch command is asserted, it adds the word-scaled, sign-extended branch offset to the supplied PC. Otherwise it forwards the PC unchanged.
- The result is registered, giving one-cycle latency. The PC-select mux downstream consumes it as the next-fetch candidate.

Parameters:
- ADDR_W, 32, width of PC, offset and result.
- OFFSET_SHIFT, 2, left shift applied to the offset (bytes per word = 4).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- branch_command  input  1  1 = take branch (compute target); 0 = pass PC through.
- sign_extand  input  ADDR_W  already sign-extended 16-bit branch immediate, in words.
- pc_addr  input  ADDR_W  base PC (PC+4 as produced by the fetch stage).
- jump_addr  output  ADDR_W  registered next-address result.
- jump_taken  output  1  registered copy of branch_command aligned with jump_addr.

Behaviour:
- Reset: on the rising clk edge with rst=1, jump_addr <= 0 and jump_taken <= 0. rst has priority over all other inputs.
- Normal cycle (rst=0), on each rising edge:
  - target = pc_addr + (sign_extand << OFFSET_SHIFT), computed in ADDR_W bits. Carry-out is discarded, so the result wraps modulo 2^ADDR_W.
  - If branch_command=1: jump_addr <= target and jump_taken <= 1.
  - If branch_command=0: jump_addr <= pc_addr and jump_taken <= 0.
- Latency: exactly 1 clock from input sample to output. There is no handshake and no stall; a new input is accepted every cycle.
- Negative offsets: sign_extand is treated as two's complement. The shift preserves the sign because the upper bits are already sign-extended; shifted-out MSBs are dropped.
- Outputs change only on clock edges. There is no combinational path from inputs to outputs.
- If rst is asserted mid-operation, the next edge zeroes the outputs regardless of branch_command.
- X/unknown inputs while not in reset may propagate. Benches must apply reset before driving inputs.

Decomposition:
- Shared package cpu_pkg holds ADDR_W=32, OFFSET_SHIFT=2, and typedef addr_t (logic [ADDR_W-1:0]).
- One natural combinational sub-module, branch_target_calc:
  - Inputs: pc, offset.
  - Output: target = pc + (offset << OFFSET_SHIFT).
  - add_jump_unit_core instantiates it and adds the select mux plus the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> jump_addr=0x00000000, jump_taken=0. Release rst -> outputs follow the inputs one cycle later.
- Forward branch: branch_command=1, pc_addr=10, sign_extand=20 -> next edge jump_addr=90 (10+80), jump_taken=1.
- No branch: branch_command=0, pc_addr=0x00400010, sign_extand=0x00000005 -> jump_addr=0x00400010, jump_taken=0.
- Backward branch: branch_command=1, pc_addr=0x00400020, sign_extand=0xFFFFFFFC (-4) -> jump_addr=0x00400010.
- Wrap-around: branch_command=1, pc_addr=0xFFFFFFFC, sign_extand=0x00000002 -> jump_addr=0x00000004.
- Back-to-back and reset priority:
  - Alternate branch_command 1/0 every cycle with changing pc_addr; each result must appear exactly one cycle after its inputs.
  - Assert rst together with branch_command=1 -> outputs become 0, not the target.
